toy_fetch_unit: RTL
===================

# toy_fetch_unit

Instruction-fetch stage for the TOY multicycle accumulator CPU, directly upstream of the controller. Owns the program counter and instruction register, runs the request/acknowledge handshake to instruction memory, and presents `opcode` and the address field to the controller. It executes the controller's `ir_wr`, `pc_wr` and `src_pc` commands and reports fetch status back to it.

## Interface
- `AW`, 12, PC and address-field width
- `DW`, 16, instruction width; opcode = `ir[DW-1:DW-4]`
- `TMO`, 15, maximum wait cycles for `mem_ack` before a fetch error (1..255)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `ir_wr`  in  1  controller fetch command; sampled only in IDLE
- `pc_wr`  in  1  PC update command
- `src_pc`  in  2  PC source: 00 PC+1, 01 `imm`, 10 `alu_res`, 11 hold
- `alu_res`  in  AW  computed jump target
- `mem_req`  out  1  instruction-memory request, registered
- `mem_addr`  out  AW  request address, registered and stable while `mem_req`=1
- `mem_ack`  in  1  memory acknowledge; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  DW  instruction word
- `ir`  out  DW  instruction register
- `opcode`  out  4  `ir[DW-1:DW-4]`
- `imm`  out  AW  `ir[AW-1:0]`
- `pc`  out  AW  program counter
- `fetch_busy`  out  1  high in REQ and DONE; controller holds IF while high
- `fetch_valid`  out  1  one-cycle pulse when `ir` has just been loaded
- `fetch_err`  out  1  sticky timeout flag; cleared only by reset

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE → REQ on `ir_wr`: `mem_req`=1 and `mem_addr`=`pc`, both registered; the timeout counter clears to 0.
- REQ with `mem_ack`=1: `ir` ← `mem_rdata`, `mem_req` ← 0, go to DONE.
- REQ with no ack: the counter increments. When the counter reaches `TMO`: `ir` ← 0 (opcode 0000, halt), `fetch_err` ← 1, `mem_req` ← 0, go to DONE.
- DONE: `fetch_valid`=1 for exactly one cycle, then IDLE.
- `pc_wr` in IDLE: `pc` updates at the next edge according to `src_pc`.
- `pc_wr` in REQ or DONE: the command is latched as pending; the last command wins. It is applied on the DONE→IDLE edge so that `mem_addr` never changes mid-handshake.
- PC+1 wraps modulo 2^AW (0xFFF → 0x000). Source 11 leaves `pc` unchanged and still clears the pending command.
- `ir_wr` outside IDLE is ignored.
- A `mem_ack` in IDLE or DONE is ignored.
- Reset values: `pc`=0, `ir`=0, `mem_req`=0, `mem_addr`=0, `fetch_busy`=0, `fetch_valid`=0, `fetch_err`=0, state IDLE, pending command cleared, prefetch buffer invalid.
- Reset mid-REQ: `mem_req` drops asynchronously. A late ack after release is ignored.

## Timing
- Memory fetch: `ir_wr` in cycle 0 → `mem_req` high in cycle 1. With the earliest ack (also cycle 1), `ir` and `fetch_valid` are valid in cycle 2.
- General case: ack in cycle N → `ir` updated and `fetch_valid`=1 in cycle N+1; `pc` (pending update) valid in cycle N+2.
- Timeout: `mem_req` high for exactly `TMO`+1 cycles, then `fetch_err`=1 in the next cycle.
- Prefetch hit (macro enabled): `ir_wr` in cycle 0 → `ir` and `fetch_valid` in cycle 1; no `mem_req`.

## Configuration
- Macro: `TOY_FETCH_PREFETCH_EN`.
- When the macro is defined, a one-entry prefetch buffer (`pbuf`, `pbuf_addr`, `pbuf_valid`) is added:
  - After DONE, if the pending command was PC+1, the block issues a background request for the new `pc` and stores the result on ack.
  - On a later `ir_wr` with `pbuf_valid` and `pbuf_addr`==`pc`, `ir` loads from `pbuf`; the block passes through DONE and the buffer is invalidated.
  - A `pc_wr` with `src_pc` of 01 or 10 invalidates the buffer. If that request is still in flight, the handshake completes and its data is discarded.
  - `ir_wr` during an in-flight prefetch waits for that prefetch to complete, then either hits the buffer or starts a fresh request.
  - A prefetch timeout silently drops the buffer and does not set `fetch_err`.
- When the macro is undefined, every fetch goes to memory and there is no background traffic.

## Test plan
- Reset release, then `ir_wr`+`pc_wr`(00), ack on cycle 3 with 0x1A05 → `opcode`=1, `imm`=0x A05, `fetch_valid` in cycle 4, `pc`=1 in cycle 5.
- `pc`=0xFFF, fetch with `src_pc`=00 → `pc` wraps to 0x000; `mem_addr` held at 0xFFF throughout REQ.
- Fetch with no ack → `mem_req` high for 16 cycles, then `ir`=0, `fetch_err`=1; a further fetch still works and `fetch_err` stays 1.
- `pc_wr`(01) then `pc_wr`(10, `alu_res`=0x123) during REQ → `pc`=0x123 after DONE.
- Reset asserted mid-REQ, ack arrives after release → `mem_req`=0 immediately, `ir`=0, no `fetch_valid`.
- With `TOY_FETCH_PREFETCH_EN`: sequential fetches hit the buffer (`ir_wr` → `fetch_valid` in 1 cycle). A jump via `src_pc`=01 forces a memory fetch at `imm`.

Source files
------------

// File: rtl/toy_fetch_unit_if.sv
// Instruction-memory handshake bundle for toy_fetch_unit.
// The fetch unit drives req/addr (master); memory returns ack/rdata (slave).
// rdata is valid in the same cycle ack is high.
interface toy_fetch_unit_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/toy_fetch_unit.sv
// toy_fetch_unit: instruction-fetch stage of the TOY accumulator CPU.
// Owns pc and ir, runs the req/ack handshake to instruction memory and
// executes the controller's ir_wr / pc_wr / src_pc commands.
// Optional feature: define TOY_FETCH_PREFETCH_EN to add a one-entry
// sequential prefetch buffer. Without it every fetch goes to memory.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for ir_wr; pc_wr applied directly (background prefetch
//        | may be in flight when the prefetch buffer is built in)
// S_REQ  | demand request outstanding, timeout counter running
// S_DONE | ir just loaded, fetch_valid high; pending pc command applied
// S_PFW  | ir_wr arrived while a prefetch was in flight; wait for it
module toy_fetch_unit #(
  parameter int AW  = 12,
  parameter int DW  = 16,
  parameter int TMO = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ir_wr,
  input  logic             pc_wr,
  input  logic [1:0]       src_pc,
  input  logic [AW-1:0]    alu_res,
  toy_fetch_unit_if.master mem,
  output logic [DW-1:0]    ir,
  output logic [3:0]       opcode,
  output logic [AW-1:0]    imm,
  output logic [AW-1:0]    pc,
  output logic             fetch_busy,
  output logic             fetch_valid,
  output logic             fetch_err
);

  localparam int CW = 8;
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  localparam logic [1:0] SRC_INC  = 2'b00;
  localparam logic [1:0] SRC_IMM  = 2'b01;
  localparam logic [1:0] SRC_ALU  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_PFW} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  // Timeout is a down-counter loaded with TMO; expiry is the terminal count 0.
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          pend_vld_q, pend_vld_d;
  logic [1:0]    pend_src_q, pend_src_d;
  logic [AW-1:0] pend_tgt_q, pend_tgt_d;

`ifdef TOY_FETCH_PREFETCH_EN
  logic [DW-1:0] pbuf_q, pbuf_d;
  logic [AW-1:0] pbuf_addr_q, pbuf_addr_d;
  logic          pbuf_valid_q, pbuf_valid_d;
  logic          pf_act_q, pf_act_d;
  logic          pf_drop_q, pf_drop_d;
`endif

  // Jump targets are captured when the command is issued, so a pending
  // 01 refers to the imm of the instruction that issued it.
  logic [AW-1:0] cmd_tgt;
  logic          done_vld;
  logic [1:0]    done_src;
  logic [AW-1:0] done_tgt;

  assign cmd_tgt  = (src_pc == SRC_ALU) ? alu_res : ir_q[AW-1:0];
  // A command arriving in DONE itself is the newest one and wins.
  assign done_vld = pc_wr | pend_vld_q;
  assign done_src = pc_wr ? src_pc  : pend_src_q;
  assign done_tgt = pc_wr ? cmd_tgt : pend_tgt_q;

  function automatic logic [AW-1:0] next_pc(input logic [1:0] src,
                                            input logic [AW-1:0] cur,
                                            input logic [AW-1:0] tgt);
    case (src)
      SRC_INC:          return cur + AW'(1);
      SRC_IMM, SRC_ALU: return tgt;
      default:          return cur;
    endcase
  endfunction

  // Next-state and next-output computation for the whole fetch stage.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    tmo_cnt_d  = tmo_cnt_q;
    pend_vld_d = pend_vld_q;
    pend_src_d = pend_src_q;
    pend_tgt_d = pend_tgt_q;
`ifdef TOY_FETCH_PREFETCH_EN
    pbuf_d       = pbuf_q;
    pbuf_addr_d  = pbuf_addr_q;
    pbuf_valid_d = pbuf_valid_q;
    pf_act_d     = pf_act_q;
    pf_drop_d    = pf_drop_q;

    // Background prefetch progress; a timeout just drops the buffer.
    if (pf_act_q) begin
      if (mem.mem_ack) begin
        pf_act_d  = 1'b0;
        mem_req_d = 1'b0;
        pf_drop_d = 1'b0;
        if (!pf_drop_q) begin
          pbuf_d       = mem.mem_rdata;
          pbuf_valid_d = 1'b1;
        end
      end else if (tmo_cnt_q == '0) begin
        pf_act_d     = 1'b0;
        mem_req_d    = 1'b0;
        pf_drop_d    = 1'b0;
        pbuf_valid_d = 1'b0;
      end else begin
        tmo_cnt_d = tmo_cnt_q - CW'(1);
      end
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (ir_wr) begin
          busy_d = 1'b1;
          // pc must not move until this fetch is done, so hold the command.
          if (pc_wr) begin
            pend_vld_d = 1'b1;
            pend_src_d = src_pc;
            pend_tgt_d = cmd_tgt;
          end
`ifdef TOY_FETCH_PREFETCH_EN
          if (pf_act_q) begin
            state_d = S_PFW;
          end else if (pbuf_valid_q && (pbuf_addr_q == pc_q)) begin
            ir_d         = pbuf_q;
            pbuf_valid_d = 1'b0;
            valid_d      = 1'b1;
            state_d      = S_DONE;
          end else begin
            state_d    = S_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            tmo_cnt_d  = TMO_C;
          end
`else
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          tmo_cnt_d  = TMO_C;
`endif
        end else if (pc_wr) begin
          pc_d = next_pc(src_pc, pc_q, cmd_tgt);
        end
      end

      S_REQ: begin
        if (pc_wr) begin
          pend_vld_d = 1'b1;
          pend_src_d = src_pc;
          pend_tgt_d = cmd_tgt;
        end
        if (mem.mem_ack) begin
          ir_d      = mem.mem_rdata;
          mem_req_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = S_DONE;
        end else if (tmo_cnt_q == '0) begin
          // Timed out: hand the controller a halt opcode and flag it.
          ir_d      = '0;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - CW'(1);
        end
      end

      S_DONE: begin
        busy_d     = 1'b0;
        pend_vld_d = 1'b0;
        state_d    = S_IDLE;
        if (done_vld) begin
          pc_d = next_pc(done_src, pc_q, done_tgt);
`ifdef TOY_FETCH_PREFETCH_EN
          if (done_src == SRC_INC) begin
            pf_act_d     = 1'b1;
            pf_drop_d    = 1'b0;
            mem_req_d    = 1'b1;
            mem_addr_d   = pc_d;
            pbuf_addr_d  = pc_d;
            pbuf_valid_d = 1'b0;
            tmo_cnt_d    = TMO_C;
          end else if (done_src != 2'b11) begin
            pbuf_valid_d = 1'b0;
          end
`endif
        end
      end

`ifdef TOY_FETCH_PREFETCH_EN
      S_PFW: begin
        if (pc_wr) begin
          pend_vld_d = 1'b1;
          pend_src_d = src_pc;
          pend_tgt_d = cmd_tgt;
        end
        // Resolve one cycle after the prefetch finished, from registered state.
        if (!pf_act_q) begin
          if (pbuf_valid_q && (pbuf_addr_q == pc_q)) begin
            ir_d         = pbuf_q;
            pbuf_valid_d = 1'b0;
            valid_d      = 1'b1;
            state_d      = S_DONE;
          end else begin
            state_d    = S_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            tmo_cnt_d  = TMO_C;
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

`ifdef TOY_FETCH_PREFETCH_EN
    // Any jump makes the buffered word stale; an in-flight one is discarded.
    if (pc_wr && ((src_pc == SRC_IMM) || (src_pc == SRC_ALU))) begin
      pbuf_valid_d = 1'b0;
      pf_drop_d    = pf_act_d;
    end
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      tmo_cnt_q  <= '0;
      pend_vld_q <= 1'b0;
      pend_src_q <= 2'b11;
      pend_tgt_q <= '0;
`ifdef TOY_FETCH_PREFETCH_EN
      pbuf_q       <= '0;
      pbuf_addr_q  <= '0;
      pbuf_valid_q <= 1'b0;
      pf_act_q     <= 1'b0;
      pf_drop_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      tmo_cnt_q  <= tmo_cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_src_q <= pend_src_d;
      pend_tgt_q <= pend_tgt_d;
`ifdef TOY_FETCH_PREFETCH_EN
      pbuf_q       <= pbuf_d;
      pbuf_addr_q  <= pbuf_addr_d;
      pbuf_valid_q <= pbuf_valid_d;
      pf_act_q     <= pf_act_d;
      pf_drop_q    <= pf_drop_d;
`endif
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign ir           = ir_q;
  assign opcode       = ir_q[DW-1:DW-4];
  assign imm          = ir_q[AW-1:0];
  assign pc           = pc_q;
  assign fetch_busy   = busy_q;
  assign fetch_valid  = valid_q;
  assign fetch_err    = err_q;

endmodule
